// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit: opcodes,
// FSM state encoding, iteration count and conditional-negate helpers.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_COUNT - 1);

  // Two's-complement negate when neg is set; doubles as absolute value.
  function automatic logic [31:0] cond_neg32(input logic [31:0] value, input logic neg);
    logic [31:0] result;
    if (neg) begin
      result = (~value) + 32'd1;
    end else begin
      result = value;
    end
    return result;
  endfunction

  function automatic logic [63:0] cond_neg64(input logic [63:0] value, input logic neg);
    logic [63:0] result;
    if (neg) begin
      result = (~value) + 64'd1;
    end else begin
      result = value;
    end
    return result;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply step or
// restoring-division step on the 64-bit working accumulator.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic        is_div,
  input  logic [63:0] acc,
  input  logic [31:0] operand,
  output logic [63:0] acc_next
);

  logic [32:0] sum_s;
  logic [32:0] rem_shift_s;
  logic [31:0] diff_s;
  logic        fits_s;

  // Multiply consumes the multiplier LSB-first from acc[31:0]; divide shifts
  // the dividend out of acc[31:0] into the remainder while quotient bits
  // enter from the right.
  always_comb begin
    sum_s       = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
    rem_shift_s = {acc[63:32], acc[31]};
    fits_s      = (rem_shift_s >= {1'b0, operand});
    diff_s      = rem_shift_s[31:0] - operand;
    if (is_div) begin
      if (fits_s) begin
        acc_next = {diff_s, acc[30:0], 1'b1};
      end else begin
        acc_next = {rem_shift_s[31:0], acc[30:0], 1'b0};
      end
    end else begin
      acc_next = {sum_s, acc[31:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential 32-bit MULT/MULTU/DIV/DIVU unit with architectural HI/LO,
// MTHI/MTLO moves, flush and synchronous active-low reset.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HiRe,
  output logic [WIDTH-1:0] LoRe
);

  state_e           state_r;
  state_e           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [63:0]      acc_r;
  logic [31:0]      opnd_r;
  logic             is_div_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  logic             is_mul_s;
  logic             is_div_op_s;
  logic             is_signed_s;
  logic             is_mthi_s;
  logic             is_mtlo_s;
  logic             div_zero_s;
  logic             a_neg_s;
  logic             b_neg_s;
  logic [31:0]      mag_a_s;
  logic [31:0]      mag_b_s;
  logic             issue_s;
  logic             load_s;
  logic             load_zero_s;
  logic             mthi_we_s;
  logic             mtlo_we_s;
  logic             step_s;
  logic             fix_s;
  logic             commit_s;
  logic [63:0]      step_acc_s;
  logic [63:0]      fix_acc_s;

  // Opcode decode
  always_comb begin
    is_mul_s    = 1'b0;
    is_div_op_s = 1'b0;
    is_signed_s = 1'b0;
    is_mthi_s   = 1'b0;
    is_mtlo_s   = 1'b0;
    case (Op)
      OP_MULT:  begin is_mul_s = 1'b1;    is_signed_s = 1'b1; end
      OP_MULTU: begin is_mul_s = 1'b1;    end
      OP_DIV:   begin is_div_op_s = 1'b1; is_signed_s = 1'b1; end
      OP_DIVU:  begin is_div_op_s = 1'b1; end
      OP_MTHI:  begin is_mthi_s = 1'b1;   end
      OP_MTLO:  begin is_mtlo_s = 1'b1;   end
      default:  begin is_mul_s = 1'b0;    end
    endcase
  end

  assign div_zero_s = is_div_op_s && (busB == {WIDTH{1'b0}});
  assign a_neg_s    = is_signed_s & busA[WIDTH-1];
  assign b_neg_s    = is_signed_s & busB[WIDTH-1];
  assign mag_a_s    = cond_neg32(busA, a_neg_s);
  assign mag_b_s    = cond_neg32(busB, b_neg_s);

  // FSM state register
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; Flush overrides everything but reset
  always_comb begin
    state_nxt_s = state_r;
    if (Flush) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (load_s) begin
            state_nxt_s = ST_CALC;
          end else if (load_zero_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_CALC: begin
          if (cnt_r == CNT_LAST) begin
            state_nxt_s = ST_FIX;
          end else begin
            state_nxt_s = ST_CALC;
          end
        end
        ST_FIX:  state_nxt_s = ST_DONE;
        ST_DONE: state_nxt_s = ST_IDLE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // FSM output/control decode; Start is only honoured in IDLE
  always_comb begin
    issue_s     = (state_r == ST_IDLE) && Start && !Flush;
    load_s      = issue_s && (is_mul_s || (is_div_op_s && !div_zero_s));
    load_zero_s = issue_s && div_zero_s;
    mthi_we_s   = issue_s && is_mthi_s;
    mtlo_we_s   = issue_s && is_mtlo_s;
    step_s      = (state_r == ST_CALC) && !Flush;
    fix_s       = (state_r == ST_FIX) && !Flush;
    commit_s    = (state_r == ST_DONE) && !Flush;
  end

  muldiv_step u_step (
    .is_div   (is_div_r),
    .acc      (acc_r),
    .operand  (opnd_r),
    .acc_next (step_acc_s)
  );

  // Sign correction: divide negates halves independently, multiply the whole product
  always_comb begin
    if (is_div_r) begin
      fix_acc_s = {cond_neg32(acc_r[63:32], neg_r_r), cond_neg32(acc_r[31:0], neg_q_r)};
    end else begin
      fix_acc_s = cond_neg64(acc_r, neg_q_r);
    end
  end

  // Working registers and iteration counter
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      acc_r    <= 64'd0;
      opnd_r   <= 32'd0;
      cnt_r    <= {CNT_W{1'b0}};
      is_div_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
    end else if (load_s) begin
      acc_r    <= {32'd0, (is_div_op_s ? mag_a_s : mag_b_s)};
      opnd_r   <= is_div_op_s ? mag_b_s : mag_a_s;
      cnt_r    <= {CNT_W{1'b0}};
      is_div_r <= is_div_op_s;
      neg_q_r  <= a_neg_s ^ b_neg_s;
      neg_r_r  <= is_div_op_s & a_neg_s;
    end else if (load_zero_s) begin
      acc_r    <= {busA, 32'hFFFF_FFFF};
      opnd_r   <= 32'd0;
      cnt_r    <= {CNT_W{1'b0}};
      is_div_r <= 1'b1;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
    end else if (step_s) begin
      acc_r <= step_acc_s;
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (fix_s) begin
      acc_r <= fix_acc_s;
    end else begin
      acc_r <= acc_r;
    end
  end

  // Architectural HI/LO: written by a completing mul/div or by MTHI/MTLO
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      hi_r <= {WIDTH{1'b0}};
      lo_r <= {WIDTH{1'b0}};
    end else if (commit_s) begin
      hi_r <= acc_r[63:32];
      lo_r <= acc_r[31:0];
    end else begin
      if (mthi_we_s) begin
        hi_r <= busA;
      end else begin
        hi_r <= hi_r;
      end
      if (mtlo_we_s) begin
        lo_r <= busA;
      end else begin
        lo_r <= lo_r;
      end
    end
  end

  // Registered status outputs
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != ST_IDLE);
      done_r <= commit_s;
    end
  end

  assign Busy = busy_r;
  assign Done = done_r;
  assign HiRe = hi_r;
  assign LoRe = lo_r;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected HI/LO/latency are queued at issue
// and compared when Done pulses; directed flush, reset and move scenarios.
module tb_muldiv_seq;

  localparam logic [2:0] OPC_MULT  = 3'b000;
  localparam logic [2:0] OPC_MULTU = 3'b001;
  localparam logic [2:0] OPC_DIV   = 3'b010;
  localparam logic [2:0] OPC_DIVU  = 3'b011;
  localparam logic [2:0] OPC_MTHI  = 3'b100;
  localparam logic [2:0] OPC_MTLO  = 3'b101;
  localparam logic [2:0] OPC_RSVD  = 3'b110;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] busA;
  logic [31:0] busB;
  logic        Flush;
  logic        Busy;
  logic        Done;
  logic [31:0] HiRe;
  logic [31:0] LoRe;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t        scoreboard[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  muldiv_seq dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Start (Start),
    .Op    (Op),
    .busA  (busA),
    .busB  (busB),
    .Flush (Flush),
    .Busy  (Busy),
    .Done  (Done),
    .HiRe  (HiRe),
    .LoRe  (LoRe)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "bench timeout");
  end

  task automatic check_eq(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference: {HI, LO} from plain 64-bit arithmetic
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] uq;
    logic [63:0] ur;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 64'd0;
    case (op)
      OPC_MULT:  p = sa * sb;
      OPC_MULTU: p = ua * ub;
      OPC_DIV: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      OPC_DIVU: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          p = {ur[31:0], uq[31:0]};
        end
      end
      default: p = 64'd0;
    endcase
    return p;
  endfunction

  // Called at a negedge; returns at the negedge after the sampling edge
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit expect_result);
    logic [63:0] r;
    exp_t        e;
    Start = 1'b1;
    Op    = op;
    busA  = a;
    busB  = b;
    if (expect_result) begin
      r     = model(op, a, b);
      e.hi  = r[63:32];
      e.lo  = r[31:0];
      e.lat = (op[1] && (b == 32'd0)) ? 1 : 34;
      scoreboard.push_back(e);
    end
    @(negedge Clk);
    Start     = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input bit flush_in_done);
    bit   seen = 1'b0;
    int   lat = 0;
    exp_t e;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge Clk);
      if (Done === 1'b1) begin
        seen = 1'b1;
        lat  = cyc - start_cyc;
      end
    end
    check_eq("done_seen", 64'(seen), 64'd1);
    if (seen) begin
      check_eq("sb_depth", 64'(scoreboard.size()), 64'd1);
      if (scoreboard.size() > 0) begin
        e = scoreboard.pop_front();
        model_hi = e.hi;
        model_lo = e.lo;
        check_eq("latency", 64'(lat), 64'(e.lat));
        check_eq("hi", 64'(HiRe), 64'(e.hi));
        check_eq("lo", 64'(LoRe), 64'(e.lo));
      end
      if (flush_in_done) Flush = 1'b1;
      @(negedge Clk);
      Flush = 1'b0;
      check_eq("done_pulse", 64'(Done), 64'd0);
      check_eq("hi_hold", 64'(HiRe), 64'(model_hi));
      check_eq("lo_hold", 64'(LoRe), 64'(model_lo));
    end else begin
      scoreboard.delete();
    end
  endtask

  initial begin
    int          done_cnt;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    Rst_n = 1'b0;
    Start = 1'b0;
    Flush = 1'b0;
    Op    = 3'b000;
    busA  = 32'd0;
    busB  = 32'd0;
    repeat (3) @(negedge Clk);
    check_eq("rst_busy", 64'(Busy), 64'd0);
    check_eq("rst_done", 64'(Done), 64'd0);
    check_eq("rst_hi", 64'(HiRe), 64'd0);
    check_eq("rst_lo", 64'(LoRe), 64'd0);
    Rst_n = 1'b1;
    @(negedge Clk);

    // MTHI / MTLO take effect at the sampling edge, no Done
    issue(OPC_MTHI, 32'h1234_5678, 32'd0, 1'b0);
    model_hi = 32'h1234_5678;
    check_eq("mthi_hi", 64'(HiRe), 64'(model_hi));
    check_eq("mthi_done", 64'(Done), 64'd0);
    check_eq("mthi_busy", 64'(Busy), 64'd0);
    issue(OPC_MTLO, 32'hCAFE_0001, 32'd0, 1'b0);
    model_lo = 32'hCAFE_0001;
    check_eq("mtlo_lo", 64'(LoRe), 64'(model_lo));
    check_eq("mtlo_hi", 64'(HiRe), 64'(model_hi));

    // Directed mul/div
    issue(OPC_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);
    check_eq("calc_busy", 64'(Busy), 64'd1);
    wait_done(1'b0);
    issue(OPC_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1);
    wait_done(1'b0);
    issue(OPC_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done(1'b0);
    issue(OPC_DIVU, 32'd100, 32'd7, 1'b1);
    wait_done(1'b0);
    issue(OPC_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(1'b0);
    issue(OPC_DIVU, 32'd5, 32'd0, 1'b1);
    wait_done(1'b0);

    // Start while busy ignored, then Flush aborts without Done
    issue(OPC_MULT, 32'd3, 32'd5, 1'b0);
    repeat (4) @(negedge Clk);
    Start = 1'b1;
    Op    = OPC_MTLO;
    busA  = 32'hDEAD_BEEF;
    @(negedge Clk);
    Start = 1'b0;
    repeat (4) @(negedge Clk);
    Flush = 1'b1;
    @(negedge Clk);
    Flush = 1'b0;
    check_eq("flush_busy", 64'(Busy), 64'd0);
    check_eq("flush_hi", 64'(HiRe), 64'(model_hi));
    check_eq("flush_lo", 64'(LoRe), 64'(model_lo));
    done_cnt = 0;
    repeat (40) begin
      @(negedge Clk);
      if (Done === 1'b1) done_cnt++;
    end
    check_eq("flush_no_done", 64'(done_cnt), 64'd0);

    // Reserved opcode ignored
    issue(OPC_RSVD, 32'h5555_AAAA, 32'd3, 1'b0);
    check_eq("rsvd_busy", 64'(Busy), 64'd0);
    @(negedge Clk);
    check_eq("rsvd_hi", 64'(HiRe), 64'(model_hi));
    check_eq("rsvd_lo", 64'(LoRe), 64'(model_lo));

    // Random mul/div against the model
    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      issue(rop, ra, rb, 1'b1);
      wait_done(1'b0);
    end

    // Flush during the Done cycle keeps the written result
    issue(OPC_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
    wait_done(1'b1);
    issue(OPC_DIVU, 32'h0BAD_F00D, 32'd0, 1'b1);
    wait_done(1'b1);

    // Reset mid-CALC clears everything
    issue(OPC_MULT, 32'h1111_1111, 32'h2222_2222, 1'b0);
    repeat (10) @(negedge Clk);
    check_eq("midcalc_busy", 64'(Busy), 64'd1);
    Rst_n = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    check_eq("midrst_busy", 64'(Busy), 64'd0);
    check_eq("midrst_done", 64'(Done), 64'd0);
    check_eq("midrst_hi", 64'(HiRe), 64'd0);
    check_eq("midrst_lo", 64'(LoRe), 64'd0);
    done_cnt = 0;
    repeat (40) begin
      @(negedge Clk);
      if (Done === 1'b1) done_cnt++;
    end
    check_eq("midrst_no_done", 64'(done_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 32, meaning the operand and HI/LO register width; the only supported value is 32.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- Clk  input  1  rising-edge clock
- Rst_n  input  1  synchronous active-low reset
- Start  input  1  issue request, sampled on a rising edge
- Op  input  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others reserved
- busA  input  32  operand A: multiplicand, dividend, or MTHI/MTLO data
- busB  input  32  operand B: multiplier or divisor
- Flush  input  1  abort the operation in flight
- Busy  output  1  operation in progress
- Done  output  1  one-cycle pulse when HI/LO are updated by a mul/div
- HiRe  output  32  architectural HI register
- LoRe  output  32  architectural LO register

Function
REQ-004 The block SHALL implement states IDLE, CALC, FIX and DONE.
REQ-005 IDLE with Start=1 and Op in {MULT, MULTU, DIV, DIVU} and divisor nonzero (for DIV/DIVU):
- latch the operand magnitudes (absolute values for signed ops) into working registers;
- record the result signs;
- clear the iteration counter;
- go to CALC.
REQ-006 CALC SHALL run exactly 32 cycles, counter 0..31.
- Multiply: shift-add, one bit per cycle, into a 64-bit working product.
- Divide: restoring division, one quotient bit per cycle.
- After count 31, go to FIX.
REQ-007 FIX SHALL apply signs:
- signed product negated iff busA[31]^busB[31];
- quotient negated iff the dividend and divisor signs differ;
- remainder takes the sign of the dividend.
FIX then goes to DONE.
REQ-008 DONE SHALL write {HiRe,LoRe} on entry and assert Done=1 for exactly one cycle, then return to IDLE.
- Multiply: HI = product[63:32], LO = product[31:0].
- Divide: HI = remainder, LO = quotient.
REQ-009 Start-to-Done latency SHALL be 34 cycles: Start sampled at edge 0, Done high during the cycle after edge 34, HI/LO visible from edge 34.
REQ-010 Busy SHALL be 1 in CALC, FIX and DONE, and 0 in IDLE.
REQ-011 Start while Busy=1 SHALL be ignored: no state, operand or HI/LO change.
REQ-012 MTHI/MTLO with Start=1 in IDLE SHALL write busA to HiRe/LoRe at that same edge, stay in IDLE, and leave Done=0.
REQ-013 Reserved Op with Start=1 SHALL be ignored.
REQ-014 DIV/DIVU with busB=0 SHALL go directly to DONE with HI=busA and LO=32'hFFFF_FFFF, giving Done 1 cycle after Start.
REQ-015 DIV of 32'h8000_0000 by 32'hFFFF_FFFF SHALL yield LO=32'h8000_0000 and HI=0, with no exception output.
REQ-016 HiRe/LoRe SHALL change only at a DONE entry, MTHI/MTLO, or reset; working registers SHALL be separate from HiRe/LoRe.
REQ-017 Flush=1 in any state SHALL return the block to IDLE at the next edge.
- HiRe/LoRe keep their old values; Done stays 0.
- Flush outranks Start in the same cycle.
- Flush in the DONE cycle does not undo HI/LO already written on DONE entry.

Reset
REQ-018 Rst_n=0 at a rising edge SHALL force:
- state=IDLE, Busy=0, Done=0;
- HiRe=0, LoRe=0;
- counter and working registers = 0.
This holds for reset in any state, including mid-CALC.
REQ-019 Reset SHALL take priority over Flush and Start.

Structure
REQ-020 The Op encodings, state encodings and the iteration count constant (32) SHALL live in a shared package, muldiv_pkg.
REQ-021 One sub-module, muldiv_step, SHALL be the combinational single-iteration shift-add / restore-subtract step; the FSM, counter and HI/LO registers stay in muldiv_seq.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- MULT busA=-3 (32'hFFFF_FFFD), busB=7 -> Done at cycle 34, HiRe=32'hFFFF_FFFF, LoRe=32'hFFFF_FFEB.
- MULTU busA=32'hFFFF_FFFF, busB=2 -> HiRe=1, LoRe=32'hFFFF_FFFE.
- DIV busA=-7, busB=2 -> LoRe=-3 (32'hFFFF_FFFD), HiRe=-1 (32'hFFFF_FFFF); DIVU 100/7 -> LoRe=14, HiRe=2.
- DIVU busB=0, busA=5 -> Done 1 cycle after Start, HiRe=5, LoRe=32'hFFFF_FFFF.
- MULT started, then Start+MTLO at cycle 5 and Flush at cycle 10 -> MTLO ignored, Busy=0 at cycle 11, HI/LO unchanged, no Done.
- MTHI busA=32'h1234_5678 -> HiRe updated the same edge, Done=0; Rst_n=0 mid-CALC -> all outputs 0 next edge.
